// File: rtl/beep_driver.sv
// Turns key and cook-done pulses into buzzer tone patterns: one short beep or a DONE_BEEPS alarm.
// Latency 1 clk from pulse to state/busy/buzzer. No backpressure; pulses arriving mid-pattern are dropped unless they are done_pulse.
module beep_driver #(
  parameter int N          = 6,
  parameter int CNT_W      = 22,
  parameter int TONE_DIV   = 6000,
  parameter int SHORT_CYC  = 1200000,
  parameter int GAP_CYC    = 1200000,
  parameter int DONE_BEEPS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_pulse,
  input  logic         done_pulse,
  input  logic         mute,
  output logic         buzzer,
  output logic         busy
);

  localparam int TW    = $clog2(TONE_DIV);
  localparam int IDX_W = $clog2(DONE_BEEPS + 1);

  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [TW-1:0]    TONE_LAST  = TW'(TONE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DONE_BEEPS - 1);

  typedef enum logic [1:0] {IDLE, KEY_ON, DONE_ON, DONE_GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0]    tcnt;
  logic [IDX_W-1:0] idx;
  logic             tone;

  // buzzer is loaded from the next tone value so it moves on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tcnt   <= '0;
      idx    <= '0;
      tone   <= 1'b0;
      buzzer <= 1'b0;
      busy   <= 1'b0;
    end else if (done_pulse) begin
      state  <= DONE_ON;
      cnt    <= '0;
      tcnt   <= '0;
      idx    <= '0;
      tone   <= 1'b1;
      buzzer <= ~mute;
      busy   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          tcnt   <= '0;
          idx    <= '0;
          if ((|key_pulse) && !mute) begin
            state  <= KEY_ON;
            tone   <= 1'b1;
            buzzer <= 1'b1;
            busy   <= 1'b1;
          end else begin
            tone   <= 1'b0;
            buzzer <= 1'b0;
            busy   <= 1'b0;
          end
        end

        KEY_ON, DONE_ON: begin
          if (cnt == SHORT_LAST) begin
            cnt    <= '0;
            tcnt   <= '0;
            tone   <= 1'b0;
            buzzer <= 1'b0;
            if (state == KEY_ON || idx == IDX_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DONE_GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (tcnt == TONE_LAST) begin
              tcnt   <= '0;
              tone   <= ~tone;
              buzzer <= ~tone & ~mute;
            end else begin
              tcnt   <= tcnt + TW'(1);
              buzzer <= tone & ~mute;
            end
          end
        end

        DONE_GAP: begin
          if (cnt == GAP_LAST) begin
            state  <= DONE_ON;
            idx    <= idx + IDX_W'(1);
            cnt    <= '0;
            tcnt   <= '0;
            tone   <= 1'b1;
            buzzer <= ~mute;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            buzzer <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tcnt   <= '0;
          idx    <= '0;
          tone   <= 1'b0;
          buzzer <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_driver.sv
// Directed bench for beep_driver with short timing parameters.
module tb_beep_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] key_pulse = '0;
  logic       done_pulse = 1'b0;
  logic       mute = 1'b0;
  logic       buzzer;
  logic       busy;

  int checks = 0;
  int errors = 0;

  beep_driver #(
    .N(6), .CNT_W(22), .TONE_DIV(4), .SHORT_CYC(20), .GAP_CYC(10), .DONE_BEEPS(3)
  ) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .done_pulse(done_pulse),
    .mute(mute), .buzzer(buzzer), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // k counts cycles from the first edge that reacts to the pulse.
  function automatic logic key_buz(int k);
    return (k < 20) && (((k / 4) % 2) == 0);
  endfunction

  function automatic logic done_buz(int k, logic m);
    int off;
    off = k % 30;
    return (k < 80) && (off < 20) && (((off / 4) % 2) == 0) && !m;
  endfunction

  initial begin
    // reset: outputs low without any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst buzzer", buzzer, 1'b0);
    chk("rst busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle busy", busy, 1'b0);

    // 1: single key beep
    key_pulse = 6'b000100;
    tick();
    key_pulse = '0;
    for (int k = 0; k < 25; k++) begin
      chk($sformatf("t1 buz k=%0d", k), buzzer, key_buz(k));
      chk($sformatf("t1 busy k=%0d", k), busy, (k < 20));
      tick();
    end

    // 2: done alarm
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    for (int k = 0; k < 85; k++) begin
      chk($sformatf("t2 buz k=%0d", k), buzzer, done_buz(k, 1'b0));
      chk($sformatf("t2 busy k=%0d", k), busy, (k < 80));
      tick();
    end

    // 3: done_pulse on clk 5 of a key beep
    key_pulse = 6'b000001;
    tick();
    key_pulse = '0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3 key buz k=%0d", k), buzzer, key_buz(k));
      chk($sformatf("t3 key busy k=%0d", k), busy, 1'b1);
      if (k == 4) done_pulse = 1'b1;
      else tick();
    end
    tick();
    done_pulse = 1'b0;
    for (int k = 0; k < 85; k++) begin
      chk($sformatf("t3 buz k=%0d", k), buzzer, done_buz(k, 1'b0));
      chk($sformatf("t3 busy k=%0d", k), busy, (k < 80));
      tick();
    end

    // 4: key and done together, then a key press in the gap
    key_pulse = 6'b100000;
    done_pulse = 1'b1;
    tick();
    key_pulse = '0;
    done_pulse = 1'b0;
    for (int k = 0; k < 85; k++) begin
      chk($sformatf("t4 buz k=%0d", k), buzzer, done_buz(k, 1'b0));
      chk($sformatf("t4 busy k=%0d", k), busy, (k < 80));
      key_pulse = (k == 24) ? 6'b111111 : 6'b000000;
      tick();
    end
    key_pulse = '0;

    // 5: mute blocks key beeps and silences the alarm
    mute = 1'b1;
    key_pulse = 6'b010000;
    tick();
    key_pulse = '0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5 key busy k=%0d", k), busy, 1'b0);
      chk($sformatf("t5 key buz k=%0d", k), buzzer, 1'b0);
      tick();
    end
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    for (int k = 0; k < 85; k++) begin
      chk($sformatf("t5 buz k=%0d", k), buzzer, done_buz(k, 1'b1));
      chk($sformatf("t5 busy k=%0d", k), busy, (k < 80));
      tick();
    end
    mute = 1'b0;

    // 6: reset at clk 7 of beep 2
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    for (int k = 0; k < 37; k++) begin
      chk($sformatf("t6 buz k=%0d", k), buzzer, done_buz(k, 1'b0));
      chk($sformatf("t6 busy k=%0d", k), busy, 1'b1);
      if (k < 36) tick();
    end
    rst = 1'b1;
    #1;
    chk("t6 async buzzer", buzzer, 1'b0);
    chk("t6 async busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("t6 post busy k=%0d", k), busy, 1'b0);
      chk($sformatf("t6 post buz k=%0d", k), buzzer, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
